// File: rtl/sq_wave_pkg.sv
// ---------------------------------------------------------------------------
// sq_wave_pkg
// Shared types and constants for the programmable square-wave generator.
//   sq_state_t  : control FSM states (IDLE, RUN, STOPPING)
//   DEF_CNT_W   : default width of the period / high-time fields
//   DEF_N_W     : default width of the burst count and period counter
//   MIN_PERIOD  : shortest period that still has both a high and a low cycle
//   sq_cfg_t    : one configuration word {period, high, n} at default widths
// ---------------------------------------------------------------------------
package sq_wave_pkg;

    localparam int DEF_CNT_W  = 32;
    localparam int DEF_N_W    = 16;
    localparam int MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } sq_state_t;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] period;
        logic [DEF_CNT_W-1:0] high;
        logic [DEF_N_W-1:0]   n;
    } sq_cfg_t;

endpackage

// File: rtl/square_wave_gen_if.sv
// ---------------------------------------------------------------------------
// square_wave_gen_if
// Configuration channel of the square-wave generator (valid/ready handshake).
//   cfg_valid  : master offers a configuration
//   cfg_ready  : slave has a free configuration slot
//   cfg_period : period P in clocks
//   cfg_high   : high time H in clocks
//   cfg_n      : periods per burst, 0 = continuous
// A configuration transfers on a cycle where cfg_valid && cfg_ready.
// ---------------------------------------------------------------------------
interface square_wave_gen_if
    import sq_wave_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int N_W   = DEF_N_W
) ();

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_high;
    logic [N_W-1:0]   cfg_n;

    modport master (
        output cfg_valid,
        output cfg_period,
        output cfg_high,
        output cfg_n,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_period,
        input  cfg_high,
        input  cfg_n,
        output cfg_ready
    );

endinterface

// File: rtl/sq_phase_cnt.sv
// ---------------------------------------------------------------------------
// sq_phase_cnt
// P-cycle phase counter of the square-wave generator. The phase k runs
// 0..P-1 while the generator is busy; the wave and period-start flags are
// registered so they line up with the registered phase.
//   sys_clk, sys_rst : clock and synchronous active-high reset
//   keep             : generator is busy in the next cycle
//   restart          : a new run begins in the next cycle (k goes to 0)
//   period, high     : active P and H
//   last             : current cycle is k = P-1 (combinational)
//   wave_out         : 1 while k < H, 0 otherwise and when idle
//   period_start     : 1 on k = 0 of every period
// ---------------------------------------------------------------------------
module sq_phase_cnt
    import sq_wave_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             keep,
    input  logic             restart,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] high,
    output logic             last,
    output logic             wave_out,
    output logic             period_start
);

    logic [CNT_W-1:0] phase_q;
    logic [CNT_W-1:0] phase_inc;
    logic             wave_q;
    logic             pstart_q;

    assign phase_inc    = phase_q + CNT_W'(1);
    assign last         = (phase_q == (period - CNT_W'(1)));
    assign wave_out     = wave_q;
    assign period_start = pstart_q;

    // A new period (fresh run or wrap) always starts high because a legal H
    // is at least 1, so the k = 0 cycle never needs to look at H. This also
    // lets the first cycle after a same-cycle configuration load be correct
    // before the new H is visible on the high input.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !keep) begin
            phase_q  <= '0;
            wave_q   <= 1'b0;
            pstart_q <= 1'b0;
        end else if (restart || last) begin
            phase_q  <= '0;
            wave_q   <= 1'b1;
            pstart_q <= 1'b1;
        end else begin
            phase_q  <= phase_inc;
            wave_q   <= (phase_inc < high);
            pstart_q <= 1'b0;
        end
    end

endmodule

// File: rtl/square_wave_gen.sv
// ---------------------------------------------------------------------------
// square_wave_gen
// Programmable square-wave source with cycle-exact period, high time and
// burst length. Configuration is double-buffered: while running, a new
// configuration waits in a one-deep pending slot and is promoted only on a
// period boundary, so the output never produces a runt pulse.
//   sys_clk, sys_rst : clock and synchronous active-high reset
//   cfg_bus          : configuration channel (slave side)
//   start            : begin output (level-sampled, ignored while busy)
//   stop             : graceful stop, current period completes
//   wave_out         : generated square wave
//   period_start     : pulse on the first cycle of each period
//   busy             : high in RUN and STOPPING
//   done             : pulse on the cycle after the final period ends
//   cfg_err          : pulse on the cycle after an illegal configuration
//   period_cnt       : completed periods in the current run
// ---------------------------------------------------------------------------
module square_wave_gen
    import sq_wave_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int N_W   = DEF_N_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    square_wave_gen_if.slave cfg_bus,
    input  logic             start,
    input  logic             stop,
    output logic             wave_out,
    output logic             period_start,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [N_W-1:0]   period_cnt
);

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
        logic [N_W-1:0]   n;
    } cfg_t;

    sq_state_t      state_q;
    sq_state_t      state_d;

    cfg_t           offer;
    cfg_t           active_q;
    cfg_t           pending_q;
    logic           active_valid_q;
    logic           pending_full_q;

    logic           cfg_fire;
    logic           cfg_legal;
    logic           cfg_take;
    logic           launch;
    logic           boundary;
    logic           burst_end;
    logic           keep_running;
    logic           phase_last;

    logic [N_W-1:0] period_cnt_q;
    logic [N_W:0]   period_num;
    logic           done_q;
    logic           cfg_err_q;

    assign offer             = {cfg_bus.cfg_period, cfg_bus.cfg_high, cfg_bus.cfg_n};
    assign cfg_bus.cfg_ready = !pending_full_q;
    assign cfg_fire          = cfg_bus.cfg_valid && !pending_full_q;

    // Legal means at least one high and one low cycle: P >= 2, 1 <= H < P.
    assign cfg_legal = (offer.period >= CNT_W'(MIN_PERIOD)) &&
                       (offer.high != '0) &&
                       (offer.high < offer.period);
    assign cfg_take  = cfg_fire && cfg_legal;

    // A start may be backed by a configuration arriving in the same cycle.
    assign launch    = (state_q == IDLE) && start && (active_valid_q || cfg_take);
    assign boundary  = (state_q != IDLE) && phase_last;

    // The period now running is number period_cnt + 1. The extra bit keeps the
    // comparison honest at the top of the counter range, and >= ends the run
    // at the next boundary if a shorter burst was promoted mid-run.
    assign period_num = {1'b0, period_cnt_q} + (N_W+1)'(1);
    assign burst_end  = (active_q.n != '0) && (period_num >= {1'b0, active_q.n});

    // Next-state logic. A stop seen on the last cycle of a period ends the run
    // at that boundary instead of costing another full period.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (boundary && (burst_end || stop)) begin
                    state_d = IDLE;
                end else if (stop) begin
                    state_d = STOPPING;
                end
            end
            STOPPING: begin
                if (boundary) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign keep_running = (state_d != IDLE);

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Configuration buffering. Idle loads go straight to the active set; busy
    // loads park in the pending slot until the next boundary. A load and a
    // promotion can never coincide because a load needs the slot empty.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            active_q       <= '0;
            pending_q      <= '0;
            active_valid_q <= 1'b0;
            pending_full_q <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else begin
            cfg_err_q <= cfg_fire && !cfg_legal;
            if (state_q == IDLE) begin
                if (cfg_take) begin
                    active_q       <= offer;
                    active_valid_q <= 1'b1;
                end
            end else begin
                if (cfg_take) begin
                    pending_q      <= offer;
                    pending_full_q <= 1'b1;
                end
                if (boundary && pending_full_q) begin
                    active_q       <= pending_q;
                    pending_full_q <= 1'b0;
                end
            end
        end
    end

    // Completed-period counter and end-of-run pulse. The counter holds in
    // idle so the final count stays readable after done.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            period_cnt_q <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= boundary && (state_d == IDLE);
            if (launch) begin
                period_cnt_q <= '0;
            end else if (boundary) begin
                period_cnt_q <= period_cnt_q + N_W'(1);
            end
        end
    end

    sq_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .keep         (keep_running),
        .restart      (launch),
        .period       (active_q.period),
        .high         (active_q.high),
        .last         (phase_last),
        .wave_out     (wave_out),
        .period_start (period_start)
    );

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign cfg_err    = cfg_err_q;
    assign period_cnt = period_cnt_q;

endmodule

// File: doc/square_wave_gen.md
# square_wave_gen

Programmable square-wave source with cycle-exact period, high time and burst length, all in `sys_clk` cycles. It is the stimulus counterpart of the square-wave frequency/duty measurement path: its output feeds that counter, both for closed-loop self-test and as a general test-signal generator. Configuration is double-buffered, so a new period or duty takes effect only on a period boundary. The output never produces a runt pulse.

## Interface
- `CNT_W`, 32, width of period and high-time fields
- `N_W`, 16, width of burst count and period counter
- `sys_clk` in 1: single clock for all logic
- `sys_rst` in 1: synchronous, active-high reset
- `cfg_valid` in 1: configuration offer
- `cfg_ready` out 1: configuration slot free; transfer on `cfg_valid && cfg_ready`
- `cfg_period` in CNT_W: period P in clocks
- `cfg_high` in CNT_W: high time H in clocks
- `cfg_n` in N_W: periods per burst; 0 = continuous
- `start` in 1: begin output, level-sampled
- `stop` in 1: graceful stop request, level-sampled
- `wave_out` out 1: generated square wave, registered
- `period_start` out 1: one-cycle pulse on the first cycle of each period
- `busy` out 1: high in RUN and STOPPING
- `done` out 1: one-cycle pulse when output ends, by burst completion or by stop
- `cfg_err` out 1: one-cycle pulse when a configuration is rejected
- `period_cnt` out N_W: completed periods in the current run; wraps modulo 2^N_W

## Operation
- Legal configuration: P ≥ 2 and 1 ≤ H ≤ P−1. Any other value is rejected: `cfg_err` = 1 on the next cycle and the registers are left unchanged.
- Registers: `active` (P, H, N plus valid flag, cleared by reset) and `pending` (one slot).
- `cfg_ready` = !pending_full.
- In IDLE, an accepted configuration writes `active` directly.
- In RUN or STOPPING, an accepted configuration goes to `pending`. It is copied to `active` at the next period boundary and `pending` is freed.
- FSM states IDLE, RUN, STOPPING:
  - IDLE → RUN: `start` = 1 and either active.valid or a legal configuration accepted in the same cycle. The same-cycle configuration is the one used.
  - If `start` is asserted with no valid configuration, it is ignored.
  - RUN → STOPPING: `stop` = 1. The current period completes.
  - RUN → IDLE: the last cycle of period number N completes, with N ≠ 0.
  - STOPPING → IDLE: the last cycle of the current period completes.
  - `start` is ignored while busy. `stop` is ignored in IDLE.
  - If `start` and `stop` arrive together in IDLE, the run starts and `stop` is ignored.
- Phase counter k runs from 0 to P−1. `wave_out` = 1 for k < H and 0 otherwise.
- `period_cnt` increments when k wraps from P−1, is cleared on IDLE → RUN, and holds in IDLE.
- Arithmetic is unsigned CNT_W-bit. Comparisons use the active values latched at the period boundary.

## Timing
- Reset values: `wave_out` = 0, `period_start` = 0, `busy` = 0, `done` = 0, `cfg_err` = 0, `cfg_ready` = 1, `period_cnt` = 0. The active and pending configurations are invalidated.
- `start` is sampled at edge t. At t+1: `wave_out` = 1, `period_start` = 1, `busy` = 1 (k = 0).
- Each period is exactly P cycles: H high cycles followed by P−H low cycles, with no gap between periods.
- End of run: the cycle after k = P−1 of the final period shows `done` = 1, `busy` = 0 and `wave_out` = 0.
- A new start is accepted no earlier than the cycle after `done`.
- A pending configuration first affects the period whose `period_start` follows the boundary. `cfg_ready` returns to 1 in that same cycle.
- If `stop` is raised during the last period of a burst, the result is a single `done` and normal burst termination.
- Reset asserted mid-run: at the next edge all outputs take their reset values. No `done` pulse is generated.

## Structure
- Package `sq_wave_pkg` holds:
  - the state enum {IDLE, RUN, STOPPING};
  - `CNT_W` and `N_W` defaults;
  - `MIN_PERIOD` = 2;
  - a configuration struct {period, high, n}.
- One sub-module, `sq_phase_cnt`: the P-cycle phase counter with wrap pulse and compare against H. The FSM, configuration buffering and legality check stay in the top level.

## Test plan
- Configure P=10, H=3, N=4, then start → four periods, each `wave_out` 3 high / 7 low. `period_start` pulses at offsets 1, 11, 21, 31. `done` at offset 41. `period_cnt` = 4.
- Continuous run with P=8, H=4. In mid-period, write P=6, H=1 → the current 8-cycle period completes, then 6-cycle periods with 1 high follow. `cfg_ready` is low from the accept until the boundary.
- Write P=1, H=0, or write P=5, H=5 → `cfg_err` pulses and the active configuration is unchanged. With no prior valid configuration, a following `start` keeps `busy` = 0.
- Continuous P=10, H=5, then raise `stop` at k=2 → the period completes (7 more cycles), then `done` = 1, `busy` = 0, `wave_out` = 0.
- Assert `sys_rst` at k=1 of a run → next cycle all outputs are at reset values. A later `start` without a new configuration is ignored.
- Assert `cfg_valid` (P=4, H=2, N=1) and `start` in the same IDLE cycle → one 4-cycle period and `done` at offset 5.
